// File: rtl/clk_div_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clk_div_ctrl_pkg                                              |
// | Brief    : Shared constants and channel state encoding for the          |
// |            dual-channel programmable clock divider.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package clk_div_ctrl_pkg;

  // Width of limit registers and divider counters
  localparam int unsigned PKG_W = 6;

  // Reset half-period limits: 200 MHz / (2*(4+1)) = 20 MHz,
  // 200 MHz / (2*(39+1)) = 2.5 MHz
  localparam logic [PKG_W-1:0] PKG_DEF_LIM1 = 6'd4;
  localparam logic [PKG_W-1:0] PKG_DEF_LIM2 = 6'd39;

  // Channel state: stopped, running, running with a queued update
  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_RUN    = 2'd1,
    ST_RELOAD = 2'd2
  } chan_state_t;

endpackage
`default_nettype wire

// File: rtl/clk_div_ctrl_chan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clk_div_chan                                                  |
// | Brief    : One divider channel: half-period counter, limit register,    |
// |            pending update, OFF/RUN/RELOAD FSM, output flop and strobe.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module clk_div_chan
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned  W       = PKG_W,
  parameter logic [W-1:0] DEF_LIM = PKG_DEF_LIM1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic [W-1:0] req_limit,
  input  logic         req_en,
  output logic         pending,
  output logic         clk_out,
  output logic         stb,
  output logic         run
);

  chan_state_t  state;
  logic [W-1:0] cnt;
  logic [W-1:0] lim;
  logic [W-1:0] plim;
  logic         pen;
  logic         pflag;
  logic         out_q;
  logic         stb_q;
  logic         run_q;
  logic         at_toggle;

  // The counter reaching the active limit marks the end of the current phase;
  // >= keeps the channel safe even if the limit ever sits below the count.
  assign at_toggle = (cnt >= lim);

  // Channel FSM with divider counter, output flop, strobe and pending update.
  // Updates only take effect at a phase boundary so no phase is ever cut short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
      lim   <= DEF_LIM;
      plim  <= '0;
      pen   <= 1'b0;
      pflag <= 1'b0;
      out_q <= 1'b0;
      stb_q <= 1'b0;
      run_q <= 1'b1;
    end else begin
      stb_q <= 1'b0;
      case (state)
        ST_OFF: begin
          cnt   <= '0;
          out_q <= 1'b0;
          if (pflag) begin
            // A stopped channel takes its update one cycle after acceptance
            lim   <= plim;
            pflag <= 1'b0;
            if (pen) begin
              state <= ST_RUN;
              run_q <= 1'b1;
            end
          end else if (req) begin
            plim  <= req_limit;
            pen   <= req_en;
            pflag <= 1'b1;
          end
        end

        ST_RUN: begin
          if (at_toggle) begin
            cnt   <= '0;
            out_q <= ~out_q;
            stb_q <= ~out_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
          // A request landing on a toggle edge is held for the next boundary
          if (req) begin
            plim  <= req_limit;
            pen   <= req_en;
            pflag <= 1'b1;
            state <= ST_RELOAD;
          end
        end

        ST_RELOAD: begin
          if (at_toggle) begin
            cnt <= '0;
            if (pen) begin
              lim   <= plim;
              pflag <= 1'b0;
              out_q <= ~out_q;
              stb_q <= ~out_q;
              state <= ST_RUN;
            end else if (out_q) begin
              // Stop only on a falling edge so the high phase is complete
              lim   <= plim;
              pflag <= 1'b0;
              out_q <= 1'b0;
              state <= ST_OFF;
              run_q <= 1'b0;
            end else begin
              // Rising boundary while a stop is queued: keep running one more phase
              out_q <= 1'b1;
              stb_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_OFF;
          cnt   <= '0;
          pflag <= 1'b0;
          out_q <= 1'b0;
          run_q <= 1'b0;
        end
      endcase
    end
  end

  assign pending = pflag;
  assign clk_out = out_q;
  assign stb     = stb_q;
  assign run     = run_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clk_div_ctrl                                                  |
// | Brief    : Two independent programmable clock dividers sharing one      |
// |            valid/ready configuration port.                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned  W        = PKG_W,
  parameter logic [W-1:0] DEF_LIM1 = PKG_DEF_LIM1,
  parameter logic [W-1:0] DEF_LIM2 = PKG_DEF_LIM2
) (
  input  logic         clk_in,
  input  logic         ar,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic         cfg_sel,
  input  logic [W-1:0] cfg_limit,
  input  logic         cfg_en,
  output logic         clk_out1,
  output logic         clk_out2,
  output logic         stb1,
  output logic         stb2,
  output logic         run1,
  output logic         run2
);

  logic accept;
  logic req1;
  logic req2;
  logic pend1;
  logic pend2;

  // Only one update may be in flight at a time across both channels; ready is
  // a direct decode of the registered pending flags, so it falls the cycle
  // after acceptance and rises the cycle after the update lands.
  assign cfg_ready = ~(pend1 | pend2);
  assign accept    = cfg_valid & cfg_ready;
  assign req1      = accept & ~cfg_sel;
  assign req2      = accept &  cfg_sel;

  clk_div_chan #(
    .W       (W),
    .DEF_LIM (DEF_LIM1)
  ) u_chan1 (
    .clk       (clk_in),
    .rst_n     (ar),
    .req       (req1),
    .req_limit (cfg_limit),
    .req_en    (cfg_en),
    .pending   (pend1),
    .clk_out   (clk_out1),
    .stb       (stb1),
    .run       (run1)
  );

  clk_div_chan #(
    .W       (W),
    .DEF_LIM (DEF_LIM2)
  ) u_chan2 (
    .clk       (clk_in),
    .rst_n     (ar),
    .req       (req2),
    .req_limit (cfg_limit),
    .req_en    (cfg_en),
    .pending   (pend2),
    .clk_out   (clk_out2),
    .stb       (stb2),
    .run       (run2)
  );

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_clk_div_ctrl                                               |
// | Brief    : Self-checking bench for clk_div_ctrl with a phase-level      |
// |            reference model and directed plus random scenarios.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_clk_div_ctrl;

  localparam int W    = 6;
  localparam int DEF1 = 4;
  localparam int DEF2 = 39;

  logic         clk_in    = 1'b0;
  logic         ar        = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_sel   = 1'b0;
  logic [W-1:0] cfg_limit = '0;
  logic         cfg_en    = 1'b0;
  logic         cfg_ready;
  logic         clk_out1, clk_out2, stb1, stb2, run1, run2;

  int n_tests = 0;
  int n_fail  = 0;

  clk_div_ctrl dut (
    .clk_in    (clk_in),
    .ar        (ar),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_sel   (cfg_sel),
    .cfg_limit (cfg_limit),
    .cfg_en    (cfg_en),
    .clk_out1  (clk_out1),
    .clk_out2  (clk_out2),
    .stb1      (stb1),
    .stb2      (stb2),
    .run1      (run1),
    .run2      (run2)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: each channel is a level plus "edges left in this phase".
  int m_lim[2];
  int m_plim[2];
  int m_left[2];
  bit m_on[2];
  bit m_lev[2];
  bit m_stb[2];
  bit m_pend[2];
  bit m_pen[2];

  function automatic bit m_ready();
    return !(m_pend[0] || m_pend[1]);
  endfunction

  always @(posedge clk_in or negedge ar) begin : model
    bit acc;
    if (!ar) begin
      m_lim[0] = DEF1;
      m_lim[1] = DEF2;
      for (int c = 0; c < 2; c++) begin
        m_on[c] = 1; m_lev[c] = 0; m_stb[c] = 0; m_pend[c] = 0; m_pen[c] = 0;
        m_left[c] = m_lim[c] + 1;
      end
    end else begin
      acc = cfg_valid && m_ready();
      for (int c = 0; c < 2; c++) begin
        m_stb[c] = 0;
        if (m_on[c]) begin
          m_left[c]--;
          if (m_left[c] == 0) begin
            if (m_pend[c] && !m_pen[c] && m_lev[c]) begin
              m_lev[c] = 0; m_on[c] = 0; m_lim[c] = m_plim[c]; m_pend[c] = 0;
            end else begin
              if (m_pend[c] && m_pen[c]) begin
                m_lim[c] = m_plim[c]; m_pend[c] = 0;
              end
              m_lev[c]  = !m_lev[c];
              m_stb[c]  = m_lev[c];
              m_left[c] = m_lim[c] + 1;
            end
          end
        end else if (m_pend[c]) begin
          m_lim[c] = m_plim[c]; m_pend[c] = 0;
          if (m_pen[c]) begin
            m_on[c] = 1; m_lev[c] = 0; m_left[c] = m_lim[c] + 1;
          end
        end
        if (acc && (int'(cfg_sel) == c)) begin
          m_pend[c] = 1; m_plim[c] = int'(cfg_limit); m_pen[c] = cfg_en;
        end
      end
    end
  end

  function automatic logic [6:0] dut_vec();
    return {cfg_ready, clk_out1, clk_out2, stb1, stb2, run1, run2};
  endfunction

  function automatic logic [6:0] mdl_vec();
    return {m_ready(), m_lev[0], m_lev[1], m_stb[0], m_stb[1], m_on[0], m_on[1]};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    ar = 1'b0;
    cfg_valid = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    n_tests++;
    if (dut_vec() !== 7'b1000011) begin
      n_fail++;
      $display("FAIL reset_state: got %b want %b", dut_vec(), 7'b1000011);
    end
    n_tests++;
    if (dut_vec() !== mdl_vec()) begin
      n_fail++;
      $display("FAIL reset_model: got %b want %b", dut_vec(), mdl_vec());
    end
    ar = 1'b1;
  endtask

  task automatic test_free_run();
    int hi1, hi2, st1, st2, first1, first2;
    hi1 = 0; hi2 = 0; st1 = 0; st2 = 0; first1 = 0; first2 = 0;
    for (int i = 1; i <= 160; i++) begin
      tick();
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL free_run cyc %0d: got %b want %b", i, dut_vec(), mdl_vec());
      end
      if (clk_out1) hi1++;
      if (clk_out2) hi2++;
      if (stb1) begin st1++; if (first1 == 0) first1 = i; end
      if (stb2) begin st2++; if (first2 == 0) first2 = i; end
    end
    n_tests++; if (first1 !== 5)  begin n_fail++; $display("FAIL free_first_rise1: got %0d want 5", first1); end
    n_tests++; if (hi1 !== 80)    begin n_fail++; $display("FAIL free_high1: got %0d want 80", hi1); end
    n_tests++; if (st1 !== 16)    begin n_fail++; $display("FAIL free_stb1: got %0d want 16", st1); end
    n_tests++; if (first2 !== 40) begin n_fail++; $display("FAIL free_first_rise2: got %0d want 40", first2); end
    n_tests++; if (hi2 !== 80)    begin n_fail++; $display("FAIL free_high2: got %0d want 80", hi2); end
    n_tests++; if (st2 !== 2)     begin n_fail++; $display("FAIL free_stb2: got %0d want 2", st2); end
  endtask

  task automatic test_reload();
    int g, rdy_low, nt;
    int tog[4];
    logic prev;
    g = 0;
    while (!stb1 && g < 40) begin tick(); g++; end
    n_tests++;
    if (!stb1) begin n_fail++; $display("FAIL reload_wait: got stb1=%b want 1", stb1); return; end
    cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_limit = 6'd9; cfg_en = 1'b1;
    prev = clk_out1; rdy_low = 0; nt = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) cfg_valid = 1'b0;
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL reload cyc %0d: got %b want %b", k, dut_vec(), mdl_vec());
      end
      if (!cfg_ready) rdy_low++;
      if (clk_out1 !== prev && nt < 4) begin tog[nt] = k; nt++; end
      prev = clk_out1;
    end
    n_tests++; if (rdy_low !== 4) begin n_fail++; $display("FAIL reload_ready_low: got %0d want 4", rdy_low); end
    n_tests++;
    if (nt !== 4 || tog[0] !== 5 || tog[1] !== 15 || tog[2] !== 25 || tog[3] !== 35) begin
      n_fail++;
      $display("FAIL reload_toggles: got n=%0d %0d %0d %0d %0d want 5 15 25 35", nt, tog[0], tog[1], tog[2], tog[3]);
    end
  endtask

  task automatic test_disable();
    int g, rise, fall, late_stb, late_hi;
    logic prev;
    g = 0;
    while (!(clk_out2 == 1'b0 && m_left[1] > 1) && g < 100) begin tick(); g++; end
    n_tests++;
    if (clk_out2 !== 1'b0) begin n_fail++; $display("FAIL disable_wait: got clk_out2=%b want 0", clk_out2); return; end
    cfg_valid = 1'b1; cfg_sel = 1'b1; cfg_limit = 6'($urandom_range(0, 63)); cfg_en = 1'b0;
    rise = 0; fall = 0; late_stb = 0; late_hi = 0; prev = clk_out2;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k == 1) cfg_valid = 1'b0;
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL disable cyc %0d: got %b want %b", k, dut_vec(), mdl_vec());
      end
      if (prev == 1'b0 && clk_out2 == 1'b1 && rise == 0) rise = k;
      if (prev == 1'b1 && clk_out2 == 1'b0 && fall == 0) fall = k;
      if (fall != 0) begin
        if (stb2) late_stb++;
        if (clk_out2) late_hi++;
      end
      prev = clk_out2;
    end
    n_tests++; if (rise == 0 || fall - rise !== 40) begin n_fail++; $display("FAIL disable_high_len: got %0d want 40", fall - rise); end
    n_tests++; if (run2 !== 1'b0) begin n_fail++; $display("FAIL disable_run2: got %b want 0", run2); end
    n_tests++; if (late_stb !== 0 || late_hi !== 0) begin n_fail++; $display("FAIL disable_quiet: got stb=%0d high=%0d want 0 0", late_stb, late_hi); end
  endtask

  task automatic test_enable_fast();
    int st, hi, alt_err;
    logic prev;
    cfg_valid = 1'b1; cfg_sel = 1'b1; cfg_limit = 6'd0; cfg_en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    n_tests++;
    if (run2 !== 1'b1 || clk_out2 !== 1'b0) begin
      n_fail++; $display("FAIL enable_start: got run2=%b clk_out2=%b want 1 0", run2, clk_out2);
    end
    st = 0; hi = 0; alt_err = 0; prev = clk_out2;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL enable cyc %0d: got %b want %b", k, dut_vec(), mdl_vec());
      end
      if (stb2) st++;
      if (clk_out2) hi++;
      if (clk_out2 === prev) alt_err++;
      prev = clk_out2;
    end
    n_tests++; if (st !== 10 || hi !== 10 || alt_err !== 0) begin
      n_fail++; $display("FAIL enable_fast: got stb=%0d high=%0d stalls=%0d want 10 10 0", st, hi, alt_err);
    end
  endtask

  task automatic test_async_reset();
    int nr;
    int rises[3];
    cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_limit = 6'd20; cfg_en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    n_tests++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL areset_pending: got ready=%b want 0", cfg_ready); end
    #2;
    ar = 1'b0;
    #1;
    n_tests++;
    if (dut_vec() !== 7'b1000011) begin
      n_fail++; $display("FAIL areset_async: got %b want %b", dut_vec(), 7'b1000011);
    end
    tick();
    ar = 1'b1;
    nr = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL areset cyc %0d: got %b want %b", k, dut_vec(), mdl_vec());
      end
      if (stb1 && nr < 3) begin rises[nr] = k; nr++; end
    end
    n_tests++;
    if (nr !== 3 || rises[0] !== 5 || rises[1] !== 15 || rises[2] !== 25) begin
      n_fail++; $display("FAIL areset_defaults: got n=%0d %0d %0d %0d want 5 15 25", nr, rises[0], rises[1], rises[2]);
    end
  endtask

  task automatic test_toggle_edge();
    int g, nt;
    int tog[4];
    logic prev;
    g = 0;
    while (m_left[0] != 1 && g < 20) begin tick(); g++; end
    n_tests++;
    if (m_left[0] != 1) begin n_fail++; $display("FAIL edge_wait: got %0d want 1", m_left[0]); return; end
    cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_limit = 6'd2; cfg_en = 1'b1;
    prev = clk_out1; nt = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) cfg_valid = 1'b0;
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL edge cyc %0d: got %b want %b", k, dut_vec(), mdl_vec());
      end
      if (clk_out1 !== prev && nt < 4) begin tog[nt] = k; nt++; end
      prev = clk_out1;
    end
    n_tests++;
    if (nt !== 4 || tog[0] !== 1 || tog[1] !== 6 || tog[2] !== 9 || tog[3] !== 12) begin
      n_fail++; $display("FAIL edge_toggles: got n=%0d %0d %0d %0d %0d want 1 6 9 12", nt, tog[0], tog[1], tog[2], tog[3]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_sel   = 1'($urandom_range(0, 1));
      cfg_limit = 6'($urandom_range(0, 11));
      cfg_en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) begin
        ar = 1'b0;
        #1;
        n_tests++;
        if (dut_vec() !== 7'b1000011) begin
          n_fail++; $display("FAIL random_reset cyc %0d: got %b want %b", k, dut_vec(), 7'b1000011);
        end
        tick();
        ar = 1'b1;
      end
      tick();
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b want %b", k, dut_vec(), mdl_vec());
      end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_reload();
    test_disable();
    test_enable_fast();
    test_async_reset();
    test_toggle_edge();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout want completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
